// File: rtl/osd_mam_arbiter.sv
// osd_mam_arbiter: round-robin arbiter that lets PORTS requesters share one memory port.
// A granted port owns the memory from request handshake through its final data beat.
module osd_mam_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int PORTS = 2,
    localparam int GW = $clog2(PORTS),
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PORTS-1:0]        in_req_valid,
    output logic [PORTS-1:0]        in_req_ready,
    input  logic [PORTS-1:0]        in_req_rw,
    input  logic [PORTS-1:0]        in_req_burst,
    input  logic [PORTS*ADDR_WIDTH-1:0] in_req_addr,
    input  logic [PORTS*14-1:0]     in_req_beats,
    input  logic [PORTS-1:0]        in_write_valid,
    output logic [PORTS-1:0]        in_write_ready,
    input  logic [PORTS*DATA_WIDTH-1:0] in_write_data,
    input  logic [PORTS*SW-1:0]     in_write_strb,
    output logic [PORTS-1:0]        in_read_valid,
    input  logic [PORTS-1:0]        in_read_ready,
    output logic [DATA_WIDTH-1:0]   in_read_data,
    output logic                    out_req_valid,
    output logic                    out_req_rw,
    output logic                    out_req_burst,
    input  logic                    out_req_ready,
    output logic [ADDR_WIDTH-1:0]   out_req_addr,
    output logic [13:0]             out_req_beats,
    output logic                    out_write_valid,
    output logic [DATA_WIDTH-1:0]   out_write_data,
    output logic [SW-1:0]           out_write_strb,
    input  logic                    out_write_ready,
    input  logic                    out_read_valid,
    input  logic [DATA_WIDTH-1:0]   out_read_data,
    output logic                    out_read_ready,
    output logic                    busy,
    output logic [GW-1:0]           grant
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;
    state_t          r_state, w_next;
    logic [GW-1:0]   r_grant, r_last_grant, w_pick;
    logic [13:0]     r_cnt, w_load;
    logic            r_rw, w_found, w_req_hs, w_beat_hs;
    assign busy   = r_state != S_IDLE;
    assign grant  = r_grant;
    assign w_load = in_req_burst[r_grant] ? in_req_beats[r_grant*14 +: 14] : 14'd1;
    // first requester found scanning upward from the port after the last winner
    always_comb begin
        logic [GW-1:0] w_idx;
        w_idx   = '0;
        w_pick  = r_last_grant;
        w_found = 1'b0;
        for (int i = 1; i <= PORTS; i++) begin
            w_idx = GW'((int'(r_last_grant) + i) % PORTS);
            if (!w_found && in_req_valid[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end
    always_comb begin
        w_next          = r_state;
        w_req_hs        = 1'b0;
        w_beat_hs       = 1'b0;
        in_req_ready    = '0;
        in_write_ready  = '0;
        in_read_valid   = '0;
        in_read_data    = '0;
        out_req_valid   = 1'b0;
        out_req_rw      = 1'b0;
        out_req_burst   = 1'b0;
        out_req_addr    = '0;
        out_req_beats   = '0;
        out_write_valid = 1'b0;
        out_write_data  = '0;
        out_write_strb  = '0;
        out_read_ready  = 1'b0;
        case (r_state)
            S_IDLE: w_next = w_found ? S_REQ : S_IDLE;
            S_REQ: begin
                out_req_valid          = in_req_valid[r_grant];
                out_req_rw             = in_req_rw[r_grant];
                out_req_burst          = in_req_burst[r_grant];
                out_req_addr           = in_req_addr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
                out_req_beats          = in_req_beats[r_grant*14 +: 14];
                in_req_ready[r_grant]  = out_req_ready;
                w_req_hs               = out_req_valid & out_req_ready;
                if (w_req_hs)
                    w_next = (w_load == 14'd0) ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (r_rw) begin
                    out_write_valid         = in_write_valid[r_grant];
                    out_write_data          = in_write_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
                    out_write_strb          = in_write_strb[r_grant*SW +: SW];
                    in_write_ready[r_grant] = out_write_ready;
                    w_beat_hs               = out_write_valid & out_write_ready;
                end else begin
                    in_read_valid[r_grant] = out_read_valid;
                    in_read_data           = out_read_data;
                    out_read_ready         = in_read_ready[r_grant];
                    w_beat_hs              = out_read_valid & out_read_ready;
                end
                if (w_beat_hs && r_cnt == 14'd1)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= GW'(PORTS - 1);
            r_grant      <= '0;
            r_cnt        <= '0;
            r_rw         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_found) begin
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
            end
            if (w_req_hs) begin
                r_rw  <= in_req_rw[r_grant];
                r_cnt <= w_load;
            end
            if (w_beat_hs)
                r_cnt <= r_cnt - 14'd1;
        end
    end
endmodule

// File: tb/tb_osd_mam_arbiter.sv
// tb_osd_mam_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level reference model of the arbiter.
module tb_osd_mam_arbiter;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int P  = 3;
    localparam int GW = $clog2(P);
    localparam int SW = DW / 8;
    logic clk = 1'b0;
    logic rst;
    logic [P-1:0]    in_req_valid, in_req_ready, in_req_rw, in_req_burst;
    logic [P*AW-1:0] in_req_addr;
    logic [P*14-1:0] in_req_beats;
    logic [P-1:0]    in_write_valid, in_write_ready;
    logic [P*DW-1:0] in_write_data;
    logic [P*SW-1:0] in_write_strb;
    logic [P-1:0]    in_read_valid, in_read_ready;
    logic [DW-1:0]   in_read_data;
    logic            out_req_valid, out_req_rw, out_req_burst, out_req_ready;
    logic [AW-1:0]   out_req_addr;
    logic [13:0]     out_req_beats;
    logic            out_write_valid, out_write_ready;
    logic [DW-1:0]   out_write_data;
    logic [SW-1:0]   out_write_strb;
    logic            out_read_valid, out_read_ready;
    logic [DW-1:0]   out_read_data;
    logic            busy;
    logic [GW-1:0]   grant;
    int n_vec = 0;
    int n_err = 0;
    // reference model: one transaction in flight, described by owner, acceptance and words left
    logic            m_busy, m_acc, m_wr;
    logic [GW-1:0]   m_own, m_last;
    int              m_left;
    // observation log for the directed scenarios
    int              q_grant[$], q_beats[$], q_cyc[$], q_after[$];
    int              wb[P], rb[P];
    int              cyc;
    logic            prev_hs;
    logic [P-1:0]    one_shot;
    always #5 clk = ~clk;
    osd_mam_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PORTS(P)) dut (
        .clk(clk), .rst(rst),
        .in_req_valid(in_req_valid), .in_req_ready(in_req_ready),
        .in_req_rw(in_req_rw), .in_req_burst(in_req_burst),
        .in_req_addr(in_req_addr), .in_req_beats(in_req_beats),
        .in_write_valid(in_write_valid), .in_write_ready(in_write_ready),
        .in_write_data(in_write_data), .in_write_strb(in_write_strb),
        .in_read_valid(in_read_valid), .in_read_ready(in_read_ready),
        .in_read_data(in_read_data),
        .out_req_valid(out_req_valid), .out_req_rw(out_req_rw),
        .out_req_burst(out_req_burst), .out_req_ready(out_req_ready),
        .out_req_addr(out_req_addr), .out_req_beats(out_req_beats),
        .out_write_valid(out_write_valid), .out_write_data(out_write_data),
        .out_write_strb(out_write_strb), .out_write_ready(out_write_ready),
        .out_read_valid(out_read_valid), .out_read_data(out_read_data),
        .out_read_ready(out_read_ready),
        .busy(busy), .grant(grant)
    );
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_busy = 1'b0;
        m_acc  = 1'b0;
        m_wr   = 1'b0;
        m_own  = '0;
        m_last = GW'(P - 1);
        m_left = 0;
    endtask
    task automatic model_clock();
        logic [GW-1:0] c;
        logic          hs;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (|in_req_valid) begin
                for (int k = 1; k <= P; k++) begin
                    c = GW'((int'(m_last) + k) % P);
                    if (in_req_valid[c]) begin
                        m_own = c;
                        break;
                    end
                end
                m_last = m_own;
                m_busy = 1'b1;
                m_acc  = 1'b0;
            end
        end else if (!m_acc) begin
            if (in_req_valid[m_own] && out_req_ready) begin
                m_wr   = in_req_rw[m_own];
                m_left = in_req_burst[m_own] ? int'(in_req_beats[m_own*14 +: 14]) : 1;
                if (m_left == 0) m_busy = 1'b0;
                else m_acc = 1'b1;
            end
        end else begin
            hs = m_wr ? (in_write_valid[m_own] && out_write_ready)
                      : (out_read_valid && in_read_ready[m_own]);
            if (hs) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_acc  = 1'b0;
                end
            end
        end
    endtask
    task automatic clr_log();
        q_grant.delete();
        q_beats.delete();
        q_cyc.delete();
        q_after.delete();
        for (int k = 0; k < P; k++) begin
            wb[k] = 0;
            rb[k] = 0;
        end
        cyc     = 0;
        prev_hs = 1'b0;
    endtask
    // one clock cycle: compare all outputs against the model, log events, advance
    task automatic step();
        logic          e_req, e_dat, hs_now;
        logic [GW-1:0] o, g;
        #1;
        o     = m_own;
        e_req = m_busy && !m_acc;
        e_dat = m_busy && m_acc;
        chk("busy", busy, m_busy);
        chk("grant", grant, o);
        chk("in_req_ready", in_req_ready, (e_req && out_req_ready) ? (64'd1 << o) : 64'd0);
        chk("out_req_valid", out_req_valid, e_req && in_req_valid[o]);
        if (e_req) begin
            chk("out_req_addr", out_req_addr, in_req_addr[o*AW +: AW]);
            chk("out_req_beats", out_req_beats, in_req_beats[o*14 +: 14]);
            chk("out_req_rw", out_req_rw, in_req_rw[o]);
            chk("out_req_burst", out_req_burst, in_req_burst[o]);
        end
        chk("in_write_ready", in_write_ready, (e_dat && m_wr && out_write_ready) ? (64'd1 << o) : 64'd0);
        chk("out_write_valid", out_write_valid, e_dat && m_wr && in_write_valid[o]);
        chk("out_write_data", out_write_data, (e_dat && m_wr) ? in_write_data[o*DW +: DW] : '0);
        chk("out_write_strb", out_write_strb, (e_dat && m_wr) ? in_write_strb[o*SW +: SW] : '0);
        chk("in_read_valid", in_read_valid, (e_dat && !m_wr && out_read_valid) ? (64'd1 << o) : 64'd0);
        chk("out_read_ready", out_read_ready, e_dat && !m_wr && in_read_ready[o]);
        if (e_dat && !m_wr) chk("in_read_data", in_read_data, out_read_data);
        hs_now = out_req_valid && out_req_ready;
        g      = grant;
        if (hs_now) begin
            q_grant.push_back(int'(grant));
            q_beats.push_back(int'(out_req_beats));
            q_cyc.push_back(cyc);
        end
        if (prev_hs) q_after.push_back(int'(busy));
        for (int k = 0; k < P; k++) begin
            if (in_write_valid[GW'(k)] && in_write_ready[GW'(k)]) wb[k]++;
            if (in_read_valid[GW'(k)] && in_read_ready[GW'(k)]) rb[k]++;
        end
        @(posedge clk);
        model_clock();
        prev_hs = hs_now;
        cyc++;
        @(negedge clk);
        if (hs_now && one_shot[g]) in_req_valid[g] = 1'b0;
    endtask
    task automatic idle_inputs();
        in_req_valid    = '0;
        in_req_rw       = '0;
        in_req_burst    = '0;
        in_req_addr     = '0;
        in_req_beats    = '0;
        in_write_valid  = '0;
        in_write_data   = '0;
        in_write_strb   = '0;
        in_read_ready   = '0;
        out_req_ready   = 1'b0;
        out_write_ready = 1'b0;
        out_read_valid  = 1'b0;
        out_read_data   = '0;
        one_shot        = '0;
    endtask
    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clr_log();
    endtask
    task automatic set_req(input logic [GW-1:0] p, input logic rw, input logic burst,
                           input int beats, input logic once);
        in_req_valid[p]           = 1'b1;
        in_req_rw[p]              = rw;
        in_req_burst[p]           = burst;
        in_req_beats[p*14 +: 14]  = 14'(beats);
        in_req_addr[p*AW +: AW]   = $urandom;
        one_shot[p]               = once;
    endtask
    task automatic randomize_inputs();
        for (int k = 0; k < P; k++) begin
            in_req_valid[GW'(k)]         = $urandom_range(9) < 3;
            in_req_rw[GW'(k)]            = 1'($urandom);
            in_req_burst[GW'(k)]         = 1'($urandom);
            in_req_beats[k*14 +: 14]     = 14'($urandom_range(5));
            in_req_addr[k*AW +: AW]      = $urandom;
            in_write_valid[GW'(k)]       = $urandom_range(9) < 7;
            in_write_data[k*DW +: DW]    = DW'($urandom);
            in_write_strb[k*SW +: SW]    = SW'($urandom);
            in_read_ready[GW'(k)]        = $urandom_range(9) < 6;
        end
        out_req_ready   = $urandom_range(9) < 6;
        out_write_ready = $urandom_range(9) < 6;
        out_read_valid  = $urandom_range(9) < 6;
        out_read_data   = DW'($urandom);
        rst             = $urandom_range(149) == 0;
    endtask
    initial begin
        idle_inputs();
        model_reset();
        clr_log();
        rst = 1'b1;
        @(negedge clk);
        reset_dut();
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, '0);
        // two competing 4-beat write bursts
        set_req(0, 1'b1, 1'b1, 4, 1'b0);
        set_req(1, 1'b1, 1'b1, 4, 1'b0);
        in_write_valid  = '1;
        out_req_ready   = 1'b1;
        out_write_ready = 1'b1;
        repeat (14) step();
        chk("a_ngrants", q_grant.size() >= 2, 1'b1);
        if (q_grant.size() >= 2) begin
            chk("a_first", q_grant[0], 0);
            chk("a_second", q_grant[1], 1);
            chk("a_spacing", q_cyc[1] - q_cyc[0], 6);
        end
        chk("a_beats_p0", wb[0], 4);
        chk("a_beats_p1", wb[1], 4);
        // single read that carries a stray beats value
        reset_dut();
        set_req(1, 1'b0, 1'b0, 9, 1'b1);
        in_read_ready  = '1;
        out_read_valid = 1'b1;
        out_req_ready  = 1'b1;
        repeat (6) step();
        chk("b_ngrants", q_grant.size(), 1);
        if (q_grant.size() == 1) begin
            chk("b_grant", q_grant[0], 1);
            chk("b_req_beats", q_beats[0], 9);
        end
        chk("b_read_beats", rb[1], 1);
        chk("b_idle", busy, 1'b0);
        // zero-length burst
        reset_dut();
        set_req(0, 1'b1, 1'b1, 0, 1'b1);
        in_write_valid  = '1;
        out_req_ready   = 1'b1;
        out_write_ready = 1'b1;
        repeat (4) step();
        chk("c_ngrants", q_grant.size(), 1);
        chk("c_after", q_after.size() >= 1, 1'b1);
        if (q_after.size() >= 1) chk("c_busy_after", q_after[0], 0);
        chk("c_beats", wb[0], 0);
        // write stall mid-burst while another port waits
        reset_dut();
        set_req(0, 1'b1, 1'b1, 8, 1'b1);
        set_req(1, 1'b1, 1'b1, 2, 1'b1);
        in_write_valid  = '1;
        out_req_ready   = 1'b1;
        out_write_ready = 1'b1;
        repeat (4) step();
        chk("d_pre_beats", wb[0], 2);
        out_write_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("d_grant", grant, '0);
            chk("d_p1_ready", in_req_ready[1], 1'b0);
        end
        chk("d_stalled", wb[0], 2);
        out_write_ready = 1'b1;
        repeat (12) step();
        chk("d_total_p0", wb[0], 8);
        chk("d_total_p1", wb[1], 2);
        chk("d_ngrants", q_grant.size(), 2);
        if (q_grant.size() == 2) chk("d_second", q_grant[1], 1);
        // fairness against a greedy port
        reset_dut();
        set_req(0, 1'b1, 1'b1, 2, 1'b0);
        set_req(1, 1'b1, 1'b1, 2, 1'b1);
        in_write_valid  = '1;
        out_req_ready   = 1'b1;
        out_write_ready = 1'b1;
        repeat (16) step();
        chk("e_ngrants", q_grant.size() >= 3, 1'b1);
        if (q_grant.size() >= 3) begin
            chk("e_g0", q_grant[0], 0);
            chk("e_g1", q_grant[1], 1);
            chk("e_g2", q_grant[2], 0);
            chk("e_wait", q_cyc[1] - q_cyc[0], 4);
        end
        // reset in the middle of a read burst
        reset_dut();
        set_req(0, 1'b0, 1'b1, 8, 1'b1);
        in_read_ready  = '1;
        out_read_valid = 1'b1;
        out_req_ready  = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("f_busy", busy, 1'b0);
        chk("f_read_ready", out_read_ready, 1'b0);
        chk("f_grant", grant, '0);
        set_req(1, 1'b0, 1'b0, 1, 1'b1);
        repeat (6) step();
        chk("f_p0_beats", rb[0], 2);
        chk("f_p1_beats", rb[1], 1);
        chk("f_ngrants", q_grant.size(), 2);
        if (q_grant.size() == 2) chk("f_regrant", q_grant[1], 1);
        // randomized traffic with occasional resets
        reset_dut();
        for (int i = 0; i < 2000; i++) begin
            randomize_inputs();
            step();
        end
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/osd_mam_arbiter.md
OSD_MAM_ARBITER -- requirements
Module: osd_mam_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: memory data width in bits; SHALL be a multiple of 16.
REQ-002 Parameter ADDR_WIDTH, default 32: memory address width in bits.
REQ-003 Parameter PORTS, default 2: number of requesters; SHALL be between 2 and 8.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_req_valid / in_req_ready  input / output  PORTS  per-port request handshake.
REQ-007 in_req_rw, in_req_burst  input  PORTS each  per-port request type: 1 = write, 1 = burst.
REQ-008 in_req_addr  input  PORTS*ADDR_WIDTH  per-port base address; port k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 in_req_beats  input  PORTS*14  per-port burst length in words.
REQ-010 in_write_valid / in_write_ready  input / output  PORTS  per-port write-beat handshake.
REQ-011 in_write_data  input  PORTS*DATA_WIDTH, and in_write_strb  input  PORTS*DATA_WIDTH/8  per-port write beat.
REQ-012 in_read_valid / in_read_ready  output / input  PORTS  per-port read-beat handshake.
REQ-013 in_read_data  output  DATA_WIDTH  read data, broadcast to all ports.
REQ-014 out_req_valid, out_req_rw, out_req_burst  output  1 each  memory request; out_req_ready  input  1.
REQ-015 out_req_addr  output  ADDR_WIDTH, and out_req_beats  output  14  memory request address and length.
REQ-016 out_write_valid  output  1, out_write_data  output  DATA_WIDTH, out_write_strb  output  DATA_WIDTH/8, out_write_ready  input  1  memory write-beat channel.
REQ-017 out_read_valid  input  1, out_read_data  input  DATA_WIDTH, out_read_ready  output  1  memory read-beat channel.
REQ-018 busy  output  1  high in any state other than IDLE; grant  output  $clog2(PORTS)  index of the port currently owning the memory.

Function
REQ-019 States SHALL be IDLE, REQ and DATA.
REQ-020 IDLE: if any in_req_valid bit is set, the arbiter SHALL pick the first set port, scanning round-robin upward from last_grant+1 modulo PORTS; it SHALL register the choice into grant and last_grant and move to REQ on the next cycle.
REQ-021 IDLE: every in_*_ready, in_read_valid and out_*_valid output SHALL be 0.
REQ-022 REQ: out_req_valid, rw, addr, burst and beats SHALL be driven combinationally from the granted port.
REQ-023 REQ: in_req_ready[grant] SHALL equal out_req_ready; all other in_req_ready bits SHALL be 0.
REQ-024 REQ handshake: the arbiter SHALL latch rw and load cnt (14 bit) with burst ? beats : 1.
REQ-025 REQ handshake: if the loaded cnt is 0, the next state SHALL be IDLE; otherwise it SHALL be DATA.
REQ-026 DATA, write: out_write_valid/data/strb SHALL come from the granted port, and in_write_ready[grant] SHALL equal out_write_ready.
REQ-027 DATA, read: in_read_valid[grant] SHALL equal out_read_valid, and out_read_ready SHALL equal in_read_ready[grant].
REQ-028 DATA: non-granted ports SHALL see 0 on every ready/valid output, and the unused data direction SHALL be held at 0.
REQ-029 Each DATA beat handshake SHALL decrement cnt; the handshake that takes cnt from 1 to 0 SHALL move the arbiter to IDLE.
REQ-030 There SHALL be exactly one IDLE cycle between consecutive transactions; ownership SHALL never change before the final beat.
REQ-031 The last beat handshake and the arrival of a new request in the same cycle SHALL be arbitrated only in the following IDLE cycle.
REQ-032 A requester dropping in_req_valid while in REQ SHALL deassert out_req_valid; the state SHALL stay REQ until the handshake completes.
REQ-033 Request-to-out_req_valid latency SHALL be 1 cycle; out_req_ready SHALL pass through to in_req_ready with 0 cycles of latency.

Reset
REQ-034 On a clock edge with rst=1: state SHALL become IDLE, last_grant SHALL become PORTS-1, grant and cnt SHALL become 0.
REQ-035 After the reset edge, all valid/ready outputs and busy SHALL read 0, including when reset arrives mid-burst; no further beats of the aborted transaction SHALL be forwarded.

Verification
REQ-036 Ports 0 and 1 both request a 4-beat burst write from reset -> port 0 is granted first, exactly 4 out_write handshakes occur, one IDLE cycle follows, then port 1 is granted.
REQ-037 Port 1 issues a single read (burst=0, beats=9) with out_read_valid held high -> out_req_beats=9, exactly 1 read beat is forwarded to port 1, then IDLE.
REQ-038 Burst with beats=0 on port 0 -> request handshake occurs, no DATA cycles, busy is low one cycle after the handshake.
REQ-039 out_write_ready is held low for 5 cycles mid-burst while port 1 requests -> grant stays 0, port 1 sees in_req_ready=0, and cnt is unchanged.
REQ-040 Port 0 requests continuously, port 1 requests once -> grant alternates 0, 1, 0; port 1 waits at most one transaction.
REQ-041 rst is asserted during beat 2 of an 8-beat read -> the next cycle shows busy=0, out_read_ready=0, and grant=0; a new request from port 1 is then granted normally.
